// File: rtl/gcd_binary_pkg.sv
// gcd_binary_pkg: shared FSM encoding and sizing helpers for the binary GCD engine
package gcd_binary_pkg;
   typedef enum logic [1:0] {
      GCD_IDLE   = 2'd0,
      GCD_SHIFT  = 2'd1,
      GCD_REDUCE = 2'd2,
      GCD_DONE   = 2'd3
   } gcd_state_t;
   function automatic int max_steps(input int width);
      return 3 * width + 3;
   endfunction
endpackage

// File: rtl/gcd_binary_if.sv
// gcd_binary_if: operand/result handshake bundle for gcd_binary
interface gcd_binary_if
   import gcd_binary_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = $clog2(max_steps(WIDTH))
);
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  in0;
   logic [WIDTH-1:0]  in1;
   logic [WIDTH-1:0]  out0;
   logic [STEP_W-1:0] out_steps;
   modport master (
      output in_valid, in0, in1, flush, out_ready,
      input  in_ready, out_valid, out0, out_steps
   );
   modport slave (
      input  in_valid, in0, in1, flush, out_ready,
      output in_ready, out_valid, out0, out_steps
   );
endinterface

// File: rtl/gcd_binary_step.sv
// gcd_binary_step: one REDUCE iteration of Stein's algorithm (halve an even side, else halve the difference)
module gcd_binary_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] a_nx,
   output logic [WIDTH-1:0] b_nx,
   output logic             eq
);
   logic a_gt;
   assign eq   = a == b;
   assign a_gt = a > b;
   // larger-minus-smaller keeps the subtraction borrow-free
   assign a_nx = !a[0] ? a >> 1 : !b[0] ? a : a_gt ? (a - b) >> 1 : a;
   assign b_nx = !a[0] ? b : !b[0] ? b >> 1 : a_gt ? b : (b - a) >> 1;
endmodule

// File: rtl/gcd_binary.sv
// gcd_binary: iterative binary GCD with valid/ready handshake, step count and synchronous flush
module gcd_binary
   import gcd_binary_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = $clog2(max_steps(WIDTH))
) (
   input logic         clk,
   input logic         nrst,
   gcd_binary_if.slave io
);
   localparam int K_W = $clog2(WIDTH + 1);
   gcd_state_t        state, state_nx;
   logic [WIDTH-1:0]  a, b, a_nx, b_nx, out0;
   logic [K_W-1:0]    k;
   logic [STEP_W-1:0] steps, out_steps;
   logic              eq, accept, both_even, zero_in;
   gcd_binary_step #(.WIDTH(WIDTH)) u_step (
      .a    (a),
      .b    (b),
      .a_nx (a_nx),
      .b_nx (b_nx),
      .eq   (eq)
   );
   assign accept       = state == GCD_IDLE && io.in_valid && !io.flush;
   assign zero_in      = io.in0 == '0 || io.in1 == '0;
   assign both_even    = !a[0] && !b[0];
   assign io.in_ready  = state == GCD_IDLE;
   assign io.out_valid = state == GCD_DONE;
   assign io.out0      = out0;
   assign io.out_steps = out_steps;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) state <= GCD_IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      if (io.flush) state_nx = GCD_IDLE;
      else
         case (state)
            GCD_IDLE:   if (io.in_valid) state_nx = zero_in ? GCD_DONE : GCD_SHIFT;
            GCD_SHIFT:  if (!both_even) state_nx = GCD_REDUCE;
            GCD_REDUCE: if (eq) state_nx = GCD_DONE;
            GCD_DONE:   if (io.out_ready) state_nx = GCD_IDLE;
            default:    state_nx = GCD_IDLE;
         endcase
   end
   // a zero operand short-circuits: the other operand is the result, no steps spent
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         a         <= '0;
         b         <= '0;
         k         <= '0;
         steps     <= '0;
         out0      <= '0;
         out_steps <= '0;
      end else if (accept) begin
         a     <= io.in0;
         b     <= io.in1;
         k     <= '0;
         steps <= '0;
         if (zero_in) begin
            out0      <= io.in0 | io.in1;
            out_steps <= '0;
         end
      end else if (!io.flush && state == GCD_SHIFT) begin
         steps <= steps + 1'b1;
         if (both_even) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
         end
      end else if (!io.flush && state == GCD_REDUCE) begin
         steps <= steps + 1'b1;
         if (eq) begin
            out0      <= a << k;
            out_steps <= steps + 1'b1;
         end else begin
            a <= a_nx;
            b <= b_nx;
         end
      end
   end
endmodule

// File: tb/tb_gcd_binary.sv
// tb_gcd_binary: directed and random checks of gcd_binary against an arithmetic GCD/step reference
module tb_gcd_binary;
   logic clk = 1'b0;
   logic nrst;
   int   checks = 0, passes = 0, fails = 0;
   int   last_g = 0, last_s = 0;
   gcd_binary_if #(.WIDTH(8))  io8 ();
   gcd_binary_if #(.WIDTH(16)) io16 ();
   gcd_binary #(.WIDTH(8))  dut8  (.clk(clk), .nrst(nrst), .io(io8.slave));
   gcd_binary #(.WIDTH(16)) dut16 (.clk(clk), .nrst(nrst), .io(io16.slave));
   always #5 clk = ~clk;
   function automatic int ref_gcd(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction
   function automatic int ref_steps(input int a, input int b);
      int n = 0;
      if (a == 0 || b == 0) return 0;
      while (a % 2 == 0 && b % 2 == 0) begin
         a = a / 2;
         b = b / 2;
         n++;
      end
      n++;
      while (a != b) begin
         if (a % 2 == 0)      a = a / 2;
         else if (b % 2 == 0) b = b / 2;
         else if (a > b)      a = (a - b) / 2;
         else                 b = (b - a) / 2;
         n++;
      end
      return n + 1;
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_op(input int a, input int b, input int hold, input string tag);
      int g, s, lat;
      g = ref_gcd(a, b);
      s = ref_steps(a, b);
      io8.in0 = 8'(a);
      io8.in1 = 8'(b);
      io8.in_valid = 1'b1;
      io8.out_ready = hold == 0;
      tick();
      io8.in_valid = 1'b0;
      lat = 0;
      while (!io8.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, ".lat"}, lat, (a == 0 || b == 0) ? 0 : s);
      check({tag, ".out0"}, io8.out0, g);
      check({tag, ".steps"}, io8.out_steps, s);
      for (int i = 0; i < hold; i++) begin
         io8.in_valid = i == 0;
         io8.in0 = 8'd9;
         io8.in1 = 8'd3;
         tick();
         check({tag, ".hold_valid"}, io8.out_valid, 1);
         check({tag, ".hold_out0"}, io8.out0, g);
         check({tag, ".hold_steps"}, io8.out_steps, s);
         check({tag, ".hold_ready"}, io8.in_ready, 0);
      end
      io8.in_valid = 1'b0;
      io8.out_ready = 1'b1;
      tick();
      io8.out_ready = 1'b0;
      check({tag, ".post_valid"}, io8.out_valid, 0);
      check({tag, ".post_ready"}, io8.in_ready, 1);
      last_g = g;
      last_s = s;
   endtask
   initial begin
      int lat, g, s, seen, ra, rb;
      nrst = 1'b0;
      {io8.in_valid, io8.flush, io8.out_ready, io8.in0, io8.in1} = '0;
      {io16.in_valid, io16.flush, io16.out_ready, io16.in0, io16.in1} = '0;
      #3;
      check("rst.in_ready", io8.in_ready, 1);
      check("rst.out_valid", io8.out_valid, 0);
      check("rst.out0", io8.out0, 0);
      check("rst.out_steps", io8.out_steps, 0);
      check("rst16.in_ready", io16.in_ready, 1);
      #9 nrst = 1'b1;
      tick();
      do_op(48, 18, 0, "48_18");
      do_op(0, 5, 0, "0_5");
      do_op(0, 0, 0, "0_0");
      do_op(7, 0, 0, "7_0");
      do_op(255, 255, 0, "255_255");
      do_op(17, 5, 0, "17_5");
      do_op(48, 18, 5, "48_18_hold");
      io8.in0 = 8'd48;
      io8.in1 = 8'd18;
      io8.in_valid = 1'b1;
      io8.out_ready = 1'b1;
      tick();
      io8.in_valid = 1'b0;
      tick();
      tick();
      io8.flush = 1'b1;
      tick();
      io8.flush = 1'b0;
      check("flush.out_valid", io8.out_valid, 0);
      check("flush.in_ready", io8.in_ready, 1);
      check("flush.out0", io8.out0, last_g);
      check("flush.out_steps", io8.out_steps, last_s);
      io8.in0 = 8'd0;
      io8.in1 = 8'd9;
      io8.in_valid = 1'b1;
      io8.flush = 1'b1;
      tick();
      io8.in_valid = 1'b0;
      io8.flush = 1'b0;
      check("flush_prio.in_ready", io8.in_ready, 1);
      check("flush_prio.out_valid", io8.out_valid, 0);
      do_op(12, 8, 0, "12_8");
      io8.in0 = 8'd200;
      io8.in1 = 8'd120;
      io8.in_valid = 1'b1;
      io8.out_ready = 1'b1;
      tick();
      io8.in_valid = 1'b0;
      tick();
      #2 nrst = 1'b0;
      #1;
      check("arst.in_ready", io8.in_ready, 1);
      check("arst.out_valid", io8.out_valid, 0);
      check("arst.out0", io8.out0, 0);
      check("arst.out_steps", io8.out_steps, 0);
      #1 nrst = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (io8.out_valid) seen++;
      end
      check("arst.no_valid", seen, 0);
      io8.out_ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         ra = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 255));
         rb = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 255));
         do_op(ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d_%0d_%0d", i, ra, rb));
      end
      g = ref_gcd(65520, 4080);
      s = ref_steps(65520, 4080);
      io16.in0 = 16'd65520;
      io16.in1 = 16'd4080;
      io16.in_valid = 1'b1;
      io16.out_ready = 1'b0;
      tick();
      io16.in_valid = 1'b0;
      lat = 0;
      while (!io16.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check("w16.lat", lat, s);
      check("w16.out0", io16.out0, g);
      check("w16.steps", io16.out_steps, s);
      check("w16.steps_bound", io16.out_steps < 51, 1);
      io16.out_ready = 1'b1;
      tick();
      check("w16.post_ready", io16.in_ready, 1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
